rot_in_stage: RTL

//  Registered input stage directly upstream of the 8-bit combinational right-rotator.

---
 rtl/rot_pkg.sv | 13 +
 rtl/rot_skid_buf.sv | 97 +++++++++
 rtl/rot_in_stage.sv | 56 +++++
 3 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the rotator input stage: default widths and skid-buffer FSM encodings.
package rot_pkg;

    localparam int ROT_W     = 8;
    localparam int ROT_AMT_W = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } rot_state_e;

endpackage

// File: rtl/rot_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with a registered output word and a registered s_ready,
// so neither the downstream data nor the upstream ready is driven from combinational logic.
module rot_skid_buf
    import rot_pkg::*;
#(
    parameter int PW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [PW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [PW-1:0] m_data
);

    rot_state_e    r_state;
    rot_state_e    w_state_nxt;
    logic          r_s_ready;
    logic          r_m_valid;
    logic [PW-1:0] r_out;
    logic [PW-1:0] r_skid;
    logic          w_s_fire;
    logic          w_m_fire;
    logic          w_load_in;
    logic          w_load_from_skid;
    logic          w_cap_skid;

    assign w_s_fire = s_valid & r_s_ready;
    assign w_m_fire = r_m_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_s_fire) w_state_nxt = ST_ONE;
            ST_ONE: begin
                if (w_s_fire && !w_m_fire) begin
                    w_state_nxt = ST_FULL;
                end else if (w_m_fire && !w_s_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL:  if (w_m_fire) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // A load into the output register happens either straight from upstream or from the skid slot.
    always_comb begin
        w_load_in        = 1'b0;
        w_load_from_skid = 1'b0;
        w_cap_skid       = 1'b0;
        case (r_state)
            ST_EMPTY: w_load_in = w_s_fire;
            ST_ONE: begin
                w_load_in  = w_s_fire & w_m_fire;
                w_cap_skid = w_s_fire & ~w_m_fire;
            end
            ST_FULL:  w_load_from_skid = w_m_fire;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_out     <= '0;
            r_skid    <= '0;
        end else begin
            r_s_ready <= (w_state_nxt != ST_FULL);
            r_m_valid <= (w_state_nxt != ST_EMPTY);
            if (w_load_in) begin
                r_out <= s_data;
            end else if (w_load_from_skid) begin
                r_out <= r_skid;
            end
            if (w_cap_skid) begin
                r_skid <= s_data;
            end
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_out;

endmodule

// File: rtl/rot_in_stage.sv
// Registered input stage feeding the combinational right-rotator.
// Optional ROT_DIR_EN adds s_dir and converts left rotates to the equivalent right amount at capture.
module rot_in_stage
    import rot_pkg::*;
#(
    parameter int W     = ROT_W,
    parameter int AMT_W = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    input  logic [AMT_W-1:0] s_amt,
`ifdef ROT_DIR_EN
    input  logic             s_dir,
`endif
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_a,
    output logic [AMT_W-1:0] m_amt
);

    localparam int PW = W + AMT_W;

    logic [AMT_W-1:0] w_amt;
    logic [PW-1:0]    w_m_data;

`ifdef ROT_DIR_EN
    // Left by n equals right by (W - n) mod W; two's-complement negation at AMT_W bits gives that.
    function automatic logic [AMT_W-1:0] norm_amt(input logic [AMT_W-1:0] amt, input logic dir);
        return dir ? ((~amt) + AMT_W'(1)) : amt;
    endfunction

    assign w_amt = norm_amt(s_amt, s_dir);
`else
    assign w_amt = s_amt;
`endif

    rot_skid_buf #(
        .PW(PW)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data ({s_data, w_amt}),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (w_m_data)
    );

    assign m_a   = w_m_data[PW-1:AMT_W];
    assign m_amt = w_m_data[AMT_W-1:0];

endmodule
